// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_if
// Description : Write/read bus of the register file: one write port addressed
//               by dst, plus two combinational read ports (dst and src).
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
);
  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH-1:0] src;
  logic [DATA_WIDTH-1:0] dstWrite;
  logic [DATA_WIDTH-1:0] dstRead;
  logic [DATA_WIDTH-1:0] srcRead;

  // Requester side: drives indices and write data, observes read data.
  modport master (
    output writeEnable, dst, src, dstWrite,
    input  dstRead, srcRead
  );

  // Register file side.
  modport slave (
    input  writeEnable, dst, src, dstWrite,
    output dstRead, srcRead
  );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : NUM_REGS x DATA_WIDTH general-purpose register file with one
//               synchronous write port and two asynchronous read ports.
//               Asynchronous active-low reset clears every register.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  register_file_if.slave  bus
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_dstRead;
  logic [DATA_WIDTH-1:0] w_srcRead;

  // One storage element per index; only the register selected by dst loads.
  // Register 0 is ordinary storage like every other index.
  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
      logic w_sel;
      assign w_sel = bus.writeEnable && (bus.dst == ADDR_WIDTH'(i));

      // Async clear has priority over any write edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_regs[i] <= '0;
        end else if (w_sel) begin
          r_regs[i] <= bus.dstWrite;
        end
      end
    end
  endgenerate

  // Read muxes straight off the storage: no write bypass, so a write in
  // flight only becomes visible after its clock edge. Indices beyond
  // NUM_REGS (possible when NUM_REGS < 2**ADDR_WIDTH) read as zero.
  always_comb begin
    w_dstRead = '0;
    w_srcRead = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.dst == ADDR_WIDTH'(i)) w_dstRead = r_regs[i];
      if (bus.src == ADDR_WIDTH'(i)) w_srcRead = r_regs[i];
    end
  end

  assign bus.dstRead = w_dstRead;
  assign bus.srcRead = w_srcRead;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file: directed scenarios and
//               randomized traffic compared against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NR = 16;

  logic clk;
  logic rst_n;
  int   passCount;
  int   totalCount;
  logic [DW-1:0] model [NR];

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Compare both read ports with what the model holds at the current indices.
  task automatic checkReads(input string tag);
    check({tag, ".dstRead"}, bus.dstRead, model[bus.dst]);
    check({tag, ".srcRead"}, bus.srcRead, model[bus.src]);
  endtask

  // Advance one rising edge; the model applies the write the edge commits.
  task automatic tick();
    @(posedge clk);
    if (rst_n && bus.writeEnable) model[bus.dst] = bus.dstWrite;
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic driveWrite(input logic we, input logic [AW-1:0] d,
                            input logic [AW-1:0] s, input logic [DW-1:0] data);
    bus.writeEnable = we;
    bus.dst         = d;
    bus.src         = s;
    bus.dstWrite    = data;
  endtask

  logic [DW-1:0] pattern;

  initial begin
    passCount  = 0;
    totalCount = 0;
    clearModel();
    rst_n = 1'b0;
    driveWrite(1'b0, 4'd3, 4'd15, '0);

    // Power-on reset: everything reads zero.
    #2;
    check("por.dst3", bus.dstRead, '0);
    check("por.src15", bus.srcRead, '0);

    // Writes while reset is held are ignored.
    driveWrite(1'b1, 4'd3, 4'd3, 64'hDEAD_BEEF_0000_1111);
    tick();
    check("resetHeldWrite", bus.dstRead, '0);
    @(negedge clk);
    bus.writeEnable = 1'b0;
    rst_n = 1'b1;

    // Write/read every register, one idle edge after each write.
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      if (i == 0)       pattern = 64'h1C8FBCBFB54D70F0;
      else if (i == 15) pattern = 64'h6306847EFE57F9AE;
      else              pattern = {$urandom, $urandom};
      driveWrite(1'b1, AW'(i), AW'(i), pattern);
      tick();
      @(negedge clk);
      bus.writeEnable = 1'b0;
      tick();
      check($sformatf("wr%0d.dst", i), bus.dstRead, pattern);
      check($sformatf("wr%0d.src", i), bus.srcRead, pattern);
    end
    // Retention sweep, with the two ports on different indices.
    for (int i = 0; i < NR; i++) begin
      bus.dst = AW'(i);
      bus.src = AW'(NR - 1 - i);
      #1;
      checkReads($sformatf("retain%0d", i));
    end

    // Dual port, distinct indices.
    @(negedge clk);
    driveWrite(1'b1, 4'd2, 4'd0, 64'hC881C482A9EC82CE);
    tick();
    @(negedge clk);
    driveWrite(1'b1, 4'd5, 4'd0, 64'h3B7066C380B594C9);
    tick();
    @(negedge clk);
    driveWrite(1'b0, 4'd2, 4'd5, '0);
    #1;
    check("dual.dst2", bus.dstRead, 64'hC881C482A9EC82CE);
    check("dual.src5", bus.srcRead, 64'h3B7066C380B594C9);

    // Write disable: all-ones on the bus across several edges.
    driveWrite(1'b0, 4'd7, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    pattern = model[7];
    repeat (3) tick();
    check("wrDisable.reg7", bus.dstRead, pattern);

    // No bypass: old value before the edge, new value after.
    @(negedge clk);
    driveWrite(1'b1, 4'd4, 4'd4, 64'h1);
    tick();
    @(negedge clk);
    bus.dstWrite = 64'h2;
    #1;
    check("bypass.pre", bus.dstRead, 64'h1);
    tick();
    check("bypass.post", bus.dstRead, 64'h2);
    @(negedge clk);
    bus.dstWrite = 64'h3;
    tick();
    check("bypass.b2b", bus.srcRead, 64'h3);

    // Randomized traffic; read ports checked just before each edge.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      driveWrite(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), {$urandom, $urandom});
      #3;
      checkReads($sformatf("rand%0d", n));
      tick();
    end

    // Reset between edges, no clock edge needed.
    @(negedge clk);
    driveWrite(1'b0, 4'd3, 4'd15, '0);
    #2;
    rst_n = 1'b0;
    clearModel();
    #1;
    check("asyncRst.dst3", bus.dstRead, '0);
    check("asyncRst.src15", bus.srcRead, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-operation reset pulse while writes are in progress.
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      driveWrite(1'b1, AW'(n + 8), AW'(n + 8), {$urandom, $urandom} | 64'h1);
      tick();
    end
    @(negedge clk);
    bus.dstWrite = 64'hAAAA_5555_AAAA_5555;
    #1;
    rst_n = 1'b0;
    #2;
    bus.writeEnable = 1'b0;
    rst_n = 1'b1;
    clearModel();
    tick();
    for (int i = 0; i < NR; i++) begin
      bus.dst = AW'(i);
      bus.src = AW'(i);
      #1;
      checkReads($sformatf("midRst%0d", i));
    end

    // Reset asserted on the same edge as a write: reset wins.
    @(negedge clk);
    driveWrite(1'b1, 4'd6, 4'd6, 64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    clearModel();
    check("rstEdge.reg6", bus.dstRead, '0);

    // First write after deassert lands normally.
    @(negedge clk);
    rst_n = 1'b1;
    driveWrite(1'b1, 4'd0, 4'd0, 64'hFEDC_BA98_7654_3210);
    tick();
    check("postRst.reg0", bus.dstRead, 64'hFEDC_BA98_7654_3210);
    checkReads("postRst");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
`default_nettype wire
